fetch_unit: RTL and testbench

- Upstream neighbour of instruction_memory in the RV32I core.
- Owns the program counter and drives the combinational instruction memory address.
- Captures the returned word into a registered fetch slot and hands it to decode over a valid/ready handshake.
- Handles branch/jump redirects, back-pressure stalls and fetch faults, and counts delivered instructions.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_pc_next_sel.sv | 39 +++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared core types for the RV32I front end.
// Fetch state, fault codes and common constants.
package core_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'd0,
      FAULT_MISALIGN = 2'd1,
      FAULT_RANGE    = 2'd2
   } fetch_fault_t;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC selection for the fetch unit.
// Purely combinational; all state lives in fetch_unit.
module pc_next_sel
   import core_pkg::*;
#(
   parameter int unsigned IMEM_BYTES = 1024
) (
   input  logic [XLEN-1:0] pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            slot_free,
   output logic [XLEN-1:0] pc_next,
   output logic            redir_ok,
   output logic            misalign,
   output logic            range_err,
   output logic            fetch
);

   logic aligned;
   logic in_range;

   assign aligned   = (redirect_target[1:0] == 2'b00);
   assign in_range  = (pc < XLEN'(IMEM_BYTES));
   assign misalign  = redirect_valid & ~aligned;
   assign redir_ok  = redirect_valid & aligned;
   assign range_err = ~redirect_valid & slot_free & ~in_range;
   assign fetch     = ~redirect_valid & slot_free & in_range;

   // redir_ok and fetch are mutually exclusive by construction
   always_comb begin
      pc_next = pc;
      unique case (1'b1)
         redir_ok: pc_next = redirect_target;
         fetch:    pc_next = pc + XLEN'(4);
         default:  pc_next = pc;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives imem,
// and presents one registered slot to decode.
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic            fault,
   output logic [1:0]      fault_code,
   output logic [XLEN-1:0] instr_count
);

   fetch_state_t    state_q, state_d;
   fetch_fault_t    code_q, code_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] opc_q, opc_d;
   logic [XLEN-1:0] cnt_q, cnt_d;
   logic            valid_q, valid_d;
   logic            fault_q, fault_d;

   logic [XLEN-1:0] pc_next;
   logic            slot_free;
   logic            redir_ok;
   logic            misalign;
   logic            range_err;
   logic            fetch;

   assign slot_free = ~valid_q | out_ready;

   pc_next_sel #(
      .IMEM_BYTES(IMEM_BYTES)
   ) u_sel (
      .pc              (pc_q),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .slot_free       (slot_free),
      .pc_next         (pc_next),
      .redir_ok        (redir_ok),
      .misalign        (misalign),
      .range_err       (range_err),
      .fetch           (fetch)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      opc_d   = opc_q;
      fault_d = fault_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
            valid_d = 1'b0;
         end
         RUN: begin
            if (valid_q && out_ready)
               cnt_d = cnt_q + XLEN'(1);
            pc_d = pc_next;
            unique case (1'b1)
               misalign: begin
                  state_d = HALT;
                  fault_d = 1'b1;
                  code_d  = FAULT_MISALIGN;
                  valid_d = 1'b0;
               end
               redir_ok: valid_d = 1'b0;
               range_err: begin
                  state_d = HALT;
                  fault_d = 1'b1;
                  code_d  = FAULT_RANGE;
                  valid_d = 1'b0;
               end
               fetch: begin
                  instr_d = imem_instr;
                  opc_d   = pc_q;
                  valid_d = 1'b1;
               end
               default: ;
            endcase
         end
         HALT: valid_d = 1'b0;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         opc_q   <= '0;
         fault_q <= 1'b0;
         code_q  <= FAULT_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
         fault_q <= fault_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_addr   = pc_q;
   assign out_valid   = valid_q;
   assign out_instr   = instr_q;
   assign out_pc      = opc_q;
   assign fault       = fault_q;
   assign fault_code  = code_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fault;
   logic [1:0]  fault_code;
   logic [31:0] instr_count;

   logic [31:0] mem [256];
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign imem_instr = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

   fetch_unit #(
      .RESET_PC   (32'h0),
      .IMEM_BYTES (1024)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .fault           (fault),
      .fault_code      (fault_code),
      .instr_count     (instr_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = 32'h0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      do_reset();
      n_chk++;
      if ({out_valid, fault, fault_code} !== 4'b0) begin
         n_fail++;
         $display("FAIL rst_flags got v=%b f=%b c=%0d want 0 0 0", out_valid, fault, fault_code);
      end
      n_chk++;
      if (out_instr !== 32'h13 || out_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_slot got %h@%h want 00000013@0", out_instr, out_pc);
      end
      n_chk++;
      if (instr_count !== 32'h0 || imem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_cnt got cnt=%0d addr=%h want 0 0", instr_count, imem_addr);
      end
   endtask

   task automatic test_basic();
      logic [31:0] epc [4];
      logic [31:0] ein [4];
      epc = '{32'h0, 32'h4, 32'h8, 32'hC};
      ein = '{32'h00100093, 32'h00200113, 32'h002081b3, 32'h00000063};
      out_ready = 1'b1;
      do_reset();
      step();
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL boot_valid got %b want 0", out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         n_chk++;
         if (out_valid !== 1'b1 || out_pc !== epc[i] || out_instr !== ein[i]) begin
            n_fail++;
            $display("FAIL seq%0d got v=%b %h@%h want 1 %h@%h",
                     i, out_valid, out_instr, out_pc, ein[i], epc[i]);
         end
         n_chk++;
         if (instr_count !== 32'(i)) begin
            n_fail++;
            $display("FAIL seq%0d_cnt got %0d want %0d", i, instr_count, i);
         end
      end
      step();
      n_chk++;
      if (instr_count !== 32'd4 || out_pc !== 32'h10) begin
         n_fail++;
         $display("FAIL cnt4 got cnt=%0d pc=%h want 4 10", instr_count, out_pc);
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b1;
      do_reset();
      step();
      step();
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++;
         if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'h00200113
             || imem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL stall%0d got v=%b %h@%h addr=%h want 1 00200113@4 8",
                     i, out_valid, out_instr, out_pc, imem_addr);
         end
      end
      n_chk++;
      if (instr_count !== 32'd1) begin
         n_fail++;
         $display("FAIL stall_cnt got %0d want 1", instr_count);
      end
      out_ready = 1'b1;
      step();
      n_chk++;
      if (out_pc !== 32'h8 || out_instr !== 32'h002081b3 || instr_count !== 32'd2) begin
         n_fail++;
         $display("FAIL unstall got %h@%h cnt=%0d want 002081b3@8 2",
                  out_instr, out_pc, instr_count);
      end
   endtask

   task automatic test_redirect();
      out_ready = 1'b1;
      do_reset();
      step();
      step();
      step();
      step();
      redirect_valid = 1'b1;
      redirect_target = 32'hC;
      step();
      redirect_valid = 1'b0;
      n_chk++;
      if (out_valid !== 1'b0 || instr_count !== 32'd3 || imem_addr !== 32'hC) begin
         n_fail++;
         $display("FAIL redir_bubble got v=%b cnt=%0d addr=%h want 0 3 c",
                  out_valid, instr_count, imem_addr);
      end
      step();
      n_chk++;
      if (out_valid !== 1'b1 || out_pc !== 32'hC || out_instr !== 32'h63
          || instr_count !== 32'd3) begin
         n_fail++;
         $display("FAIL redir_tgt got v=%b %h@%h cnt=%0d want 1 00000063@c 3",
                  out_valid, out_instr, out_pc, instr_count);
      end
   endtask

   task automatic test_misalign();
      out_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_target = 32'h6;
      step();
      n_chk++;
      if (fault !== 1'b1 || fault_code !== 2'd1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign got f=%b c=%0d v=%b want 1 1 0", fault, fault_code, out_valid);
      end
      out_ready = 1'b1;
      redirect_target = 32'h20;
      for (int i = 0; i < 10; i++) begin
         step();
         n_chk++;
         if (out_valid !== 1'b0 || fault !== 1'b1 || fault_code !== 2'd1
             || imem_addr !== 32'h10 || instr_count !== 32'd3) begin
            n_fail++;
            $display("FAIL halt%0d got v=%b f=%b c=%0d addr=%h cnt=%0d want 0 1 1 10 3",
                     i, out_valid, fault, fault_code, imem_addr, instr_count);
         end
      end
      redirect_valid = 1'b0;
   endtask

   task automatic test_range();
      out_ready = 1'b1;
      do_reset();
      step();
      step();
      redirect_valid = 1'b1;
      redirect_target = 32'h3FC;
      step();
      redirect_valid = 1'b0;
      step();
      n_chk++;
      if (out_valid !== 1'b1 || out_pc !== 32'h3FC || out_instr !== 32'h13
          || imem_addr !== 32'h400) begin
         n_fail++;
         $display("FAIL edge_fetch got v=%b %h@%h addr=%h want 1 00000013@3fc 400",
                  out_valid, out_instr, out_pc, imem_addr);
      end
      step();
      n_chk++;
      if (fault !== 1'b1 || fault_code !== 2'd2 || out_valid !== 1'b0
          || instr_count !== 32'd2) begin
         n_fail++;
         $display("FAIL range got f=%b c=%0d v=%b cnt=%0d want 1 2 0 2",
                  fault, fault_code, out_valid, instr_count);
      end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_chk++;
      if (fault !== 1'b0 || fault_code !== 2'd0 || out_valid !== 1'b0
          || instr_count !== 32'd0 || imem_addr !== 32'h0 || out_instr !== 32'h13) begin
         n_fail++;
         $display("FAIL rst_halt got f=%b c=%0d v=%b cnt=%0d addr=%h i=%h",
                  fault, fault_code, out_valid, instr_count, imem_addr, out_instr);
      end
      out_ready = 1'b1;
      step();
      step();
      step();
      out_ready = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_chk++;
      if (out_valid !== 1'b0 || out_pc !== 32'h0 || instr_count !== 32'd0
          || imem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_stall got v=%b pc=%h cnt=%0d addr=%h want 0 0 0 0",
                  out_valid, out_pc, instr_count, imem_addr);
      end
      out_ready = 1'b1;
      step();
      step();
      n_chk++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h00100093) begin
         n_fail++;
         $display("FAIL restart got v=%b %h@%h want 1 00100093@0",
                  out_valid, out_instr, out_pc);
      end
   endtask

   initial begin
      foreach (mem[i]) mem[i] = 32'h0000_0013;
      mem[0] = 32'h00100093;
      mem[1] = 32'h00200113;
      mem[2] = 32'h002081b3;
      mem[3] = 32'h00000063;
      mem[4] = 32'h00400213;
      rst_n = 1'b0;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = 32'h0;
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_misalign();
      test_range();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
